// File: rtl/result_chunk_tx.sv
// result_chunk_tx: snapshots a wide result vector and streams it to the
// host in CHUNK_W-bit chunks, one per rising edge of the host request.
// Optional even parity on oDATA: define RESULT_TX_PARITY_EN.
module result_chunk_tx #(
  parameter int DATA_W  = 810,
  parameter int CHUNK_W = 30,
  parameter int IDX_W   = 5
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic [DATA_W-1:0]  iRESULT,
  input  logic               iREQ,
  input  logic               iFINISH,
  output logic [CHUNK_W-1:0] oDATA,
  output logic [IDX_W-1:0]   oIDX,
  output logic               oVALID,
  output logic               oLAST,
  output logic               oBUSY,
  output logic               oDONE,
  output logic               oPARITY
);

  localparam int NUM_CHUNKS = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

  state_t               state_q;
  logic [DATA_W-1:0]    shadow_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 armed_q;
  logic [CHUNK_W-1:0]   data_q;
  logic [IDX_W-1:0]     oidx_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 busy_q;
  logic                 done_q;

  logic [PAD_W-1:0]                   padded;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] chunks;
  logic [CHUNK_W-1:0]                 chunk_sel;
  logic                               req_c;
  logic                               load_c;
  logic                               abort_c;
  logic                               release_c;

  // Zero-extend the snapshot so the last chunk reads padding as 0.
  always_comb begin
    padded                = '0;
    padded[DATA_W-1:0]    = shadow_q;
  end

  assign chunks    = padded;
  assign chunk_sel = chunks[idx_q];

  assign req_c     = iREQ & armed_q;
  assign abort_c   = (state_q != IDLE) & iFINISH;
  assign load_c    = (state_q == WAIT) & ~iFINISH & req_c;
  assign release_c = (state_q == SEND) & ~iFINISH & ~iREQ;

  // Transfer FSM with all outputs registered.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      armed_q  <= 1'b0;
      data_q   <= '0;
      oidx_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!iREQ) armed_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (iSTART && !iFINISH) begin
            shadow_q <= iRESULT;
            idx_q    <= '0;
            armed_q  <= ~iREQ;
            busy_q   <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (abort_c) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (load_c) begin
            data_q  <= chunk_sel;
            oidx_q  <= idx_q;
            valid_q <= 1'b1;
            last_q  <= (idx_q == LAST_IDX);
            armed_q <= 1'b0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (abort_c) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (release_c) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              idx_q   <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= WAIT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oDATA  = data_q;
  assign oIDX   = oidx_q;
  assign oVALID = valid_q;
  assign oLAST  = last_q;
  assign oBUSY  = busy_q;
  assign oDONE  = done_q;

`ifdef RESULT_TX_PARITY_EN
  logic par_q;

  // Parity travels with oDATA and drops whenever oVALID drops.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      par_q <= 1'b0;
    end else if (abort_c || release_c) begin
      par_q <= 1'b0;
    end else if (load_c) begin
      par_q <= ^chunk_sel;
    end
  end

  assign oPARITY = par_q;
`else
  assign oPARITY = 1'b0;
`endif

endmodule

// File: tb/tb_result_chunk_tx.sv
// Bench for result_chunk_tx: random and patterned vectors checked against
// a bit-level chunking model; a second 40-bit instance covers padding.
module tb_result_chunk_tx;

  localparam int DW = 810;
  localparam int CW = 30;
  localparam int NC = 27;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, req, fin;
  logic [DW-1:0] result;
  logic [CW-1:0] odata;
  logic [4:0]    oidx;
  logic          ovalid, olast, obusy, odone, opar;

  logic          s_start, s_req, s_fin;
  logic [39:0]   s_result;
  logic [CW-1:0] s_data;
  logic [0:0]    s_idx;
  logic          s_valid, s_last, s_busy, s_done, s_par;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  result_chunk_tx u_dut (
    .iCLK(clk), .iRESET(rst), .iSTART(start), .iRESULT(result),
    .iREQ(req), .iFINISH(fin), .oDATA(odata), .oIDX(oidx),
    .oVALID(ovalid), .oLAST(olast), .oBUSY(obusy), .oDONE(odone),
    .oPARITY(opar)
  );

  result_chunk_tx #(.DATA_W(40), .CHUNK_W(30), .IDX_W(1)) u_small (
    .iCLK(clk), .iRESET(rst), .iSTART(s_start), .iRESULT(s_result),
    .iREQ(s_req), .iFINISH(s_fin), .oDATA(s_data), .oIDX(s_idx),
    .oVALID(s_valid), .oLAST(s_last), .oBUSY(s_busy), .oDONE(s_done),
    .oPARITY(s_par)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] exp_chunk(input logic [DW-1:0] v,
                                              input int k);
    logic [CW-1:0] r;
    r = '0;
    for (int b = 0; b < CW; b++)
      if (k * CW + b < DW) r[b] = v[k * CW + b];
    return r;
  endfunction

  function automatic logic exp_par(input logic [CW-1:0] c);
`ifdef RESULT_TX_PARITY_EN
    int ones;
    ones = 0;
    for (int b = 0; b < CW; b++) ones += int'(c[b]);
    return (ones % 2) == 1;
`else
    return (c != c);
`endif
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Request chunks lo..hi of snapshot v, checking each against the model.
  task automatic chunk_seq(input logic [DW-1:0] v, input int lo,
                           input int hi, input string nm);
    logic [CW-1:0] e;
    logic [3:0]    fl;
    for (int k = lo; k <= hi; k++) begin
      e = exp_chunk(v, k);
      repeat ($urandom_range(0, 2)) tick();
      req = 1'b1;
      tick();
      n_chk++;
      if ({ovalid, olast} !== {1'b1, k == NC - 1}) begin
        n_fail++;
        $display("FAIL %s vld/last k=%0d: got %b want %b", nm, k,
                 {ovalid, olast}, {1'b1, k == NC - 1});
      end
      n_chk++;
      if (oidx !== 5'(k)) begin
        n_fail++;
        $display("FAIL %s idx: got %0d want %0d", nm, oidx, k);
      end
      n_chk++;
      if (odata !== e) begin
        n_fail++;
        $display("FAIL %s data k=%0d: got %h want %h", nm, k, odata, e);
      end
      n_chk++;
      if (opar !== exp_par(e)) begin
        n_fail++;
        $display("FAIL %s parity k=%0d: got %b want %b", nm, k, opar,
                 exp_par(e));
      end
      repeat ($urandom_range(0, 2)) tick();
      n_chk++;
      if ({ovalid, odata} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL %s hold k=%0d: got %b/%h want 1/%h", nm, k,
                 ovalid, odata, e);
      end
      req = 1'b0;
      tick();
      fl = (k == NC - 1) ? 4'b0001 : 4'b0010;
      n_chk++;
      if ({ovalid, olast, obusy, odone} !== fl) begin
        n_fail++;
        $display("FAIL %s release k=%0d: got %b want %b", nm, k,
                 {ovalid, olast, obusy, odone}, fl);
      end
    end
  endtask

  task automatic do_start(input logic [DW-1:0] v, input string nm);
    result = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    result = rand_vec();
    n_chk++;
    if ({ovalid, obusy, odone} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s start: got %b want 010", nm,
               {ovalid, obusy, odone});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({odata, oidx, ovalid, olast, obusy, odone, opar} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got %h/%0d/%b want all 0", odata, oidx,
               {ovalid, olast, obusy, odone, opar});
    end
    do_start(rand_vec(), "reset_mid");
    req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({odata, oidx, ovalid, olast, obusy, odone, opar} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h/%0d/%b want all 0", odata, oidx,
               {ovalid, olast, obusy, odone, opar});
    end
    req = 1'b0;
    tick();
    req = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({ovalid, obusy, odone} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_req: got %b want 000", {ovalid, obusy, odone});
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_full_transfer();
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i++) v[i] = 1'(i % 2);
    n_chk++;
    if (exp_chunk(v, 5) !== 30'h2AAAAAAA) begin
      n_fail++;
      $display("FAIL alt_model: got %h want 2aaaaaaa", exp_chunk(v, 5));
    end
    do_start(v, "alt");
    chunk_seq(v, 0, NC - 1, "alt");
    tick();
    n_chk++;
    if ({odone, obusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL alt_done_pulse: got %b want 00", {odone, obusy});
    end
    for (int r = 0; r < 2; r++) begin
      v = rand_vec();
      do_start(v, "rand");
      chunk_seq(v, 0, NC - 1, "rand");
      tick();
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] v, v2;
    v = rand_vec();
    do_start(v, "abort");
    chunk_seq(v, 0, 4, "abort");
    req = 1'b1;
    tick();
    fin = 1'b1;
    tick();
    n_chk++;
    if ({ovalid, olast, obusy, odone} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_state: got %b want 0000",
               {ovalid, olast, obusy, odone});
    end
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if ({obusy, odone} !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_idle: got %b want 00", {obusy, odone});
      end
    end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    n_chk++;
    if (obusy !== 1'b0) begin
      n_fail++;
      $display("FAIL finish_blocks_start: got %b want 0", obusy);
    end
    fin = 1'b0;
    tick();
    v2 = rand_vec();
    do_start(v2, "restart");
    chunk_seq(v2, 0, 1, "restart");
    fin = 1'b1;
    tick();
    fin = 1'b0;
    tick();
  endtask

  task automatic test_ignore_start();
    logic [DW-1:0] v;
    v = rand_vec();
    do_start(v, "ignore");
    chunk_seq(v, 0, 2, "ignore");
    req = 1'b1;
    tick();
    result = ~v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n_chk++;
    if ({ovalid, obusy, odata} !== {2'b11, exp_chunk(v, 3)}) begin
      n_fail++;
      $display("FAIL ignore_c3: got %b/%h want 11/%h", {ovalid, obusy},
               odata, exp_chunk(v, 3));
    end
    req = 1'b0;
    tick();
    chunk_seq(v, 4, NC - 1, "ignore");
    tick();
  endtask

  task automatic test_level_edge();
    logic [DW-1:0] v;
    v   = rand_vec();
    req = 1'b1;
    tick();
    result = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if ({ovalid, obusy} !== 2'b01) begin
        n_fail++;
        $display("FAIL level_hold c%0d: got %b want 01", i,
                 {ovalid, obusy});
      end
    end
    req = 1'b0;
    tick();
    req = 1'b1;
    tick();
    n_chk++;
    if ({ovalid, oidx, odata} !== {1'b1, 5'd0, exp_chunk(v, 0)}) begin
      n_fail++;
      $display("FAIL edge_c0: got %b/%0d/%h want 1/0/%h", ovalid, oidx,
               odata, exp_chunk(v, 0));
    end
    req = 1'b0;
    tick();
    fin = 1'b1;
    tick();
    fin = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v, v2;
    v  = rand_vec();
    v2 = rand_vec();
    do_start(v, "b2b_a");
    chunk_seq(v, 0, NC - 1, "b2b_a");
    do_start(v2, "b2b_b");
    chunk_seq(v2, 0, NC - 1, "b2b_b");
    tick();
    n_chk++;
    if ({odone, obusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_end: got %b want 00", {odone, obusy});
    end
  endtask

  task automatic test_padding();
    logic [29:0] e;
    logic [39:0] vals [2];
    logic [29:0] c1   [2];
    logic        p1   [2];
    vals[0] = 40'hFF_FFFF_FFFF;
    vals[1] = 40'h7F_FFFF_FFFF;
    c1[0]   = 30'h000003FF;
    c1[1]   = 30'h000001FF;
`ifdef RESULT_TX_PARITY_EN
    p1[0] = 1'b0;
    p1[1] = 1'b1;
`else
    p1[0] = 1'b0;
    p1[1] = 1'b0;
`endif
    for (int t = 0; t < 2; t++) begin
      s_result = vals[t];
      s_start  = 1'b1;
      tick();
      s_start  = 1'b0;
      for (int k = 0; k < 2; k++) begin
        e = (k == 0) ? 30'h3FFFFFFF : c1[t];
        s_req = 1'b1;
        tick();
        n_chk++;
        if ({s_valid, s_last, s_idx, s_data} !==
            {1'b1, k == 1, 1'(k), e}) begin
          n_fail++;
          $display("FAIL pad t%0d k%0d: got %b%b%b/%h want 1%b%0d/%h",
                   t, k, s_valid, s_last, s_idx, s_data, k == 1, k, e);
        end
        n_chk++;
        if (s_par !== ((k == 0) ? 1'b0 : p1[t])) begin
          n_fail++;
          $display("FAIL pad_par t%0d k%0d: got %b want %b", t, k, s_par,
                   (k == 0) ? 1'b0 : p1[t]);
        end
        s_req = 1'b0;
        tick();
      end
      n_chk++;
      if ({s_done, s_busy} !== 2'b10) begin
        n_fail++;
        $display("FAIL pad_done t%0d: got %b want 10", t, {s_done, s_busy});
      end
      tick();
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    req      = 1'b0;
    fin      = 1'b0;
    result   = '0;
    s_start  = 1'b0;
    s_req    = 1'b0;
    s_fin    = 1'b0;
    s_result = '0;
    test_reset();
    test_full_transfer();
    test_abort();
    test_ignore_start();
    test_level_edge();
    test_back_to_back();
    test_padding();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
